// File: rtl/memory_bus_interface_pkg.sv
// Shared types and constants for the memory bus interface.
// The abort data default is the NOP opcode so a timed-out fetch executes harmlessly.
package memory_bus_interface_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam logic [7:0] NOP_OPCODE = 8'hEA;

endpackage

// File: rtl/memory_bus_interface_bus_timeout_counter.sv
// Counts ACCESS cycles without an ack and flags the terminal count.
// The count stops at terminal so it cannot wrap while the bus sits idle.
module bus_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic nrst,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   logic [7:0] count;

   assign terminal = (count == 8'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         count <= 8'h00;
      end else if (clear) begin
         count <= 8'h00;
      end else if (enable && !terminal) begin
         count <= count + 8'h01;
      end
   end

endmodule

// File: rtl/memory_bus_interface.sv
// Bridges a stallable 8-bit core bus to a req/ack memory port with an ack timeout.
// One bus cycle at a time; the core is held via cpu_stall until the cycle completes or aborts.
module memory_bus_interface
   import memory_bus_interface_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter logic [7:0]  ABORT_DATA     = NOP_OPCODE
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [7:0]  cpu_addr_lo,
   input  logic [7:0]  cpu_addr_hi,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_write,
   input  logic        cpu_cycle_valid,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_stall,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        mem_req,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   input  logic        err_clear,
   output logic        timeout_err,
   output state_t      dbgState
);

   // Handshake: mem_req stays high with stable addr/wdata/we until the memory
   // returns a one-cycle mem_ack (transfer completes on that edge) or the
   // timeout fires; cpu_stall is the core-side not-ready while a cycle is open.

   state_t      state;
   state_t      stateNext;
   logic [15:0] holdAddr;
   logic [7:0]  holdWdata;
   logic        holdWrite;
   logic        startCycle;
   logic        ackSeen;
   logic        timeoutHit;
   logic        terminal;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext  = state;
      startCycle = 1'b0;
      ackSeen    = 1'b0;
      timeoutHit = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_cycle_valid) begin
               startCycle = 1'b1;
               stateNext  = ACCESS;
            end
         end
         ACCESS: begin
            // An ack on the terminal cycle completes normally.
            if (mem_ack) begin
               ackSeen   = 1'b1;
               stateNext = IDLE;
            end else if (terminal) begin
               timeoutHit = 1'b1;
               stateNext  = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   assign mem_req   = (state == ACCESS);
   assign mem_we    = (state == ACCESS) && holdWrite;
   assign mem_addr  = holdAddr;
   assign mem_wdata = holdWdata;
   assign cpu_stall = (state == ACCESS) || startCycle;
   assign dbgState  = state;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         holdAddr  <= 16'h0000;
         holdWdata <= 8'h00;
         holdWrite <= 1'b0;
      end else if (startCycle) begin
         holdAddr  <= {cpu_addr_hi, cpu_addr_lo};
         holdWdata <= cpu_wdata;
         holdWrite <= cpu_write;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cpu_rdata <= 8'h00;
      end else if (ackSeen && !holdWrite) begin
         cpu_rdata <= mem_rdata;
      end else if (timeoutHit && !holdWrite) begin
         cpu_rdata <= ABORT_DATA;
      end
   end

   // A fresh abort takes priority over a clear arriving on the same edge.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         timeout_err <= 1'b0;
      end else if (timeoutHit) begin
         timeout_err <= 1'b1;
      end else if (err_clear) begin
         timeout_err <= 1'b0;
      end
   end

   bus_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) uTimeout (
      .clk      (clk),
      .nrst     (nrst),
      .clear    (startCycle),
      .enable   ((state == ACCESS) && !mem_ack),
      .terminal (terminal)
   );

endmodule

// File: tb/tb_memory_bus_interface.sv
// Directed bench for memory_bus_interface: a vector table of bus cycles plus
// hand sequences for reset mid-access, ignored ack/valid and error clearing.
module tb_memory_bus_interface;
   import memory_bus_interface_pkg::*;

   localparam int TIMEOUT = 16;
   localparam int NO_ACK  = 255;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic        write;
      int          ackDelay;
      logic [7:0]  memData;
      logic [7:0]  expRdata;
      logic        expErr;
      logic        clrAfter;
      logic        clrAtTerm;
   } vec_t;

   logic        clk;
   logic        nrst;
   logic [7:0]  cpu_addr_lo;
   logic [7:0]  cpu_addr_hi;
   logic [7:0]  cpu_wdata;
   logic        cpu_write;
   logic        cpu_cycle_valid;
   logic [7:0]  cpu_rdata;
   logic        cpu_stall;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_req;
   logic [7:0]  mem_rdata;
   logic        mem_ack;
   logic        err_clear;
   logic        timeout_err;
   state_t      dbgState;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  expQ[$];
   vec_t        vecs[8];
   vec_t        v;

   memory_bus_interface #(
      .TIMEOUT_CYCLES(TIMEOUT),
      .ABORT_DATA    (8'hEA)
   ) dut (
      .clk            (clk),
      .nrst           (nrst),
      .cpu_addr_lo    (cpu_addr_lo),
      .cpu_addr_hi    (cpu_addr_hi),
      .cpu_wdata      (cpu_wdata),
      .cpu_write      (cpu_write),
      .cpu_cycle_valid(cpu_cycle_valid),
      .cpu_rdata      (cpu_rdata),
      .cpu_stall      (cpu_stall),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_we         (mem_we),
      .mem_req        (mem_req),
      .mem_rdata      (mem_rdata),
      .mem_ack        (mem_ack),
      .err_clear      (err_clear),
      .timeout_err    (timeout_err),
      .dbgState       (dbgState)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Driver: runs one complete bus cycle from the current negedge.
   task automatic runTxn(input vec_t t, input string nm);
      int   nCyc;
      logic tmo;
      tmo  = (t.ackDelay >= TIMEOUT);
      nCyc = tmo ? TIMEOUT : t.ackDelay + 1;
      expQ.push_back(t.expRdata);
      cpu_addr_hi     = t.addr[15:8];
      cpu_addr_lo     = t.addr[7:0];
      cpu_wdata       = t.wdata;
      cpu_write       = t.write;
      cpu_cycle_valid = 1'b1;
      #1;
      check({nm, " stall_on_valid"}, 32'(cpu_stall), 32'd1);
      check({nm, " req_low_idle"}, 32'(mem_req), 32'd0);
      @(posedge clk);
      @(negedge clk);
      cpu_cycle_valid = 1'b0;
      for (int i = 0; i < nCyc; i++) begin
         if (i == t.ackDelay) begin
            mem_ack   = 1'b1;
            mem_rdata = t.memData;
         end
         if (tmo && t.clrAtTerm && (i == nCyc - 1)) err_clear = 1'b1;
         #1;
         check({nm, " req"}, 32'(mem_req), 32'd1);
         check({nm, " addr"}, 32'(mem_addr), 32'(t.addr));
         check({nm, " we"}, 32'(mem_we), 32'(t.write));
         check({nm, " wdata"}, 32'(mem_wdata), 32'(t.wdata));
         check({nm, " stall_access"}, 32'(cpu_stall), 32'd1);
         check({nm, " state_access"}, 32'(dbgState), 32'(ACCESS));
         @(posedge clk);
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = 8'h00;
         err_clear = 1'b0;
      end
      #1;
      check({nm, " req_done"}, 32'(mem_req), 32'd0);
      check({nm, " stall_done"}, 32'(cpu_stall), 32'd0);
      check({nm, " rdata"}, 32'(cpu_rdata), 32'(expQ.pop_front()));
      check({nm, " err"}, 32'(timeout_err), 32'(t.expErr));
      if (t.clrAfter) begin
         err_clear = 1'b1;
         @(posedge clk);
         @(negedge clk);
         err_clear = 1'b0;
         #1;
         check({nm, " err_cleared"}, 32'(timeout_err), 32'd0);
      end
   endtask

   initial begin
      //            addr      wdata  wr    delay   mem    expRd  err   clrA  clrT
      vecs[0] = '{16'h1234, 8'h00, 1'b0, 0,      8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{16'h01FF, 8'hC3, 1'b1, 3,      8'h99, 8'h5A, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{16'h0000, 8'h11, 1'b0, 15,     8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{16'hABCD, 8'h22, 1'b0, NO_ACK, 8'h00, 8'hEA, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{16'h8000, 8'h55, 1'b1, NO_ACK, 8'h00, 8'hEA, 1'b1, 1'b1, 1'b1};
      vecs[5] = '{16'hFFFC, 8'h00, 1'b0, 0,      8'h11, 8'h11, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{16'hFFFD, 8'h00, 1'b0, 0,      8'h22, 8'h22, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{16'h0042, 8'h77, 1'b1, 0,      8'hBB, 8'h22, 1'b0, 1'b0, 1'b0};

      nrst            = 1'b0;
      cpu_addr_lo     = 8'h00;
      cpu_addr_hi     = 8'h00;
      cpu_wdata       = 8'h00;
      cpu_write       = 1'b0;
      cpu_cycle_valid = 1'b0;
      mem_rdata       = 8'h00;
      mem_ack         = 1'b0;
      err_clear       = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset req", 32'(mem_req), 32'd0);
      check("reset we", 32'(mem_we), 32'd0);
      check("reset addr", 32'(mem_addr), 32'h0000);
      check("reset wdata", 32'(mem_wdata), 32'h00);
      check("reset rdata", 32'(cpu_rdata), 32'h00);
      check("reset err", 32'(timeout_err), 32'd0);
      check("reset stall", 32'(cpu_stall), 32'd0);
      check("reset state", 32'(dbgState), 32'(IDLE));
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);

      // Vector table; vecs[5] and vecs[6] run back-to-back with no gap.
      for (int k = 0; k < 8; k++) begin
         runTxn(vecs[k], $sformatf("vec%0d", k));
      end

      // mem_ack while idle must not touch cpu_rdata.
      mem_ack   = 1'b1;
      mem_rdata = 8'h99;
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      check("idle_ack rdata", 32'(cpu_rdata), 32'h22);
      check("idle_ack req", 32'(mem_req), 32'd0);

      // cpu_cycle_valid and a new address during ACCESS are ignored.
      cpu_addr_hi     = 8'h33;
      cpu_addr_lo     = 8'h33;
      cpu_write       = 1'b0;
      cpu_cycle_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cpu_addr_hi = 8'h44;
      cpu_addr_lo = 8'h44;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("valid_in_access addr", 32'(mem_addr), 32'h3333);
         @(posedge clk);
         @(negedge clk);
      end
      cpu_cycle_valid = 1'b0;
      mem_ack         = 1'b1;
      mem_rdata       = 8'h66;
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      check("valid_in_access rdata", 32'(cpu_rdata), 32'h66);
      check("valid_in_access idle", 32'(dbgState), 32'(IDLE));

      // Leave an error pending, then reset in the middle of an ACCESS.
      v = '{16'h5555, 8'h00, 1'b0, NO_ACK, 8'h00, 8'hEA, 1'b1, 1'b0, 1'b0};
      runTxn(v, "pre_reset_tmo");
      cpu_addr_hi     = 8'h22;
      cpu_addr_lo     = 8'h22;
      cpu_wdata       = 8'h5C;
      cpu_write       = 1'b1;
      cpu_cycle_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cpu_cycle_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("mid_reset req_before", 32'(mem_req), 32'd1);
      nrst = 1'b0;
      #1;
      check("mid_reset req", 32'(mem_req), 32'd0);
      check("mid_reset we", 32'(mem_we), 32'd0);
      check("mid_reset addr", 32'(mem_addr), 32'h0000);
      check("mid_reset wdata", 32'(mem_wdata), 32'h00);
      check("mid_reset rdata", 32'(cpu_rdata), 32'h00);
      check("mid_reset err", 32'(timeout_err), 32'd0);
      check("mid_reset state", 32'(dbgState), 32'(IDLE));
      @(negedge clk);
      nrst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         check("no_replay req", 32'(mem_req), 32'd0);
      end
      v = '{16'h2468, 8'h00, 1'b0, 2, 8'h9C, 8'h9C, 1'b0, 1'b0, 1'b0};
      runTxn(v, "post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
